// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      ISSUE,
      WAIT_RESP,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small decode-side instruction buffer with synchronous flush.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned CW   = AW + 1
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          push,
   input  fetch_entry_t  push_entry,
   input  logic          pop,
   input  logic          flush,
   output logic [CW-1:0] count,
   output fetch_entry_t  head
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_entry;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: owns the PC, issues one cache request at a time and
// buffers returned instructions toward decode.
module fetch_pc_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_1000,
   parameter logic [31:0] EXC_VECTOR = 32'h0000_2000,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic        clock,
   input  logic        reset_n,
   output logic [31:0] itlb_vaddr,
   input  logic [31:0] itlb_paddr,
   input  logic        itlb_stall,
   output logic        icache_req_valid,
   output logic [31:0] icache_req_addr,
   input  logic        icache_req_ready,
   input  logic        icache_resp_valid,
   input  logic [31:0] icache_resp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        exc_valid,
   output logic        dec_valid,
   output logic [31:0] dec_pc,
   output logic [31:0] dec_instr,
   input  logic        dec_ready
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t  state;
   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic [31:0]   flush_pc;
   logic [CW-1:0] fifo_count;
   fetch_entry_t  fifo_head;
   fetch_entry_t  resp_entry;
   logic          flush;
   logic          handshake;
   logic          push;
   logic          pop;

   assign flush    = exc_valid || redirect_valid;
   assign flush_pc = exc_valid ? EXC_VECTOR : word_align(redirect_pc);

   // Credit rule: issue only with no request outstanding and a free FIFO slot.
   assign icache_req_valid = reset_n && (state == ISSUE) && !itlb_stall &&
                             (fifo_count < CW'(FIFO_DEPTH)) && !flush;
   assign icache_req_addr  = reset_n ? word_align(itlb_paddr) : '0;
   assign itlb_vaddr       = pc;

   assign handshake  = icache_req_valid && icache_req_ready;
   assign push       = (state == WAIT_RESP) && icache_resp_valid && !flush;
   assign pop        = dec_valid && dec_ready;
   assign resp_entry = '{pc: req_pc, instr: icache_resp_data};

   assign dec_valid = (fifo_count != '0);
   assign dec_pc    = fifo_head.pc;
   assign dec_instr = fifo_head.instr;

   // PC, request tag and outstanding-request state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state  <= ISSUE;
         pc     <= RESET_PC;
         req_pc <= '0;
      end else begin
         if (flush) begin
            pc <= flush_pc;
         end else if (handshake) begin
            pc <= pc + 32'(INSTR_BYTES);
         end
         if (handshake) begin
            req_pc <= pc;
         end
         case (state)
            ISSUE: begin
               if (handshake) state <= WAIT_RESP;
            end
            WAIT_RESP: begin
               // A flush without the response leaves it in flight to be discarded.
               if (icache_resp_valid) state <= ISSUE;
               else if (flush)        state <= DRAIN;
            end
            DRAIN: begin
               if (icache_resp_valid) state <= ISSUE;
            end
            default: state <= ISSUE;
         endcase
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock      (clock),
      .reset_n    (reset_n),
      .push       (push),
      .push_entry (resp_entry),
      .pop        (pop),
      .flush      (flush),
      .count      (fifo_count),
      .head       (fifo_head)
   );

endmodule
